// File: rtl/rx_serial_pkg.sv
// Shared constants for the parameterised serial receiver: state encodings,
// parity modes and the parity-mismatch helper.
package rx_serial_pkg;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;
  localparam logic [2:0] ST_LOAD   = 3'd5;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_EVEN = 1;
  localparam int PARITY_ODD  = 2;

  // onesXor is the XOR of all data bits and the received parity bit
  function automatic logic parityMismatch(input logic onesXor, input int mode);
    case (mode)
      PARITY_EVEN: return onesXor;
      PARITY_ODD:  return ~onesXor;
      default:     return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/rx_serial_tick.sv
// Bit-timing counter: restarts on request, flags the half-bit and full-bit
// points measured from the restart.
module rx_serial_tick #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic clock,
  input  logic reset,
  input  logic restart_i,
  output logic halfTick_o,
  output logic fullTick_o
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q + CW'(1);
    if (restart_i || cnt_q == FULL_LAST) cnt_d = '0;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign halfTick_o = (cnt_q == HALF_LAST);
  assign fullTick_o = (cnt_q == FULL_LAST);

endmodule

// File: rtl/rx_serial_param.sv
// Parameterised asynchronous serial receiver with a one-word holding register,
// sticky overrun, and an optional db_estado state port (RX_SERIAL_DEBUG_EN).
module rx_serial_param #(
  parameter int DATA_BITS    = 8,
  parameter int PARITY_MODE  = 1,
  parameter int STOP_BITS    = 1,
  parameter int CLKS_PER_BIT = 434
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 rxd,
  input  logic                 ready,
  input  logic                 clear_overrun,
  output logic [DATA_BITS-1:0] dados,
  output logic                 valid,
  output logic                 parity_error,
  output logic                 framing_error,
  output logic                 overrun,
`ifdef RX_SERIAL_DEBUG_EN
  output logic                 busy,
  output logic [2:0]           db_estado
`else
  output logic                 busy
`endif
);

  import rx_serial_pkg::*;

  localparam logic [3:0] LAST_DATA = 4'(DATA_BITS - 1);
  localparam logic [3:0] LAST_STOP = 4'(STOP_BITS - 1);

  logic                 sync1_q, rxs_q, rxsPrev_q;
  logic [2:0]           state_q, state_d;
  logic [3:0]           bitCnt_q, bitCnt_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 parityBit_q, parityBit_d;
  logic                 frameErr_q, frameErr_d;
  logic [DATA_BITS-1:0] dados_q, dados_d;
  logic                 valid_q, valid_d;
  logic                 parErr_q, parErr_d;
  logic                 frmErr_q, frmErr_d;
  logic                 overrun_q, overrun_d;
  logic                 halfTick, fullTick, restart;

  // rxsPrev_q gives the falling-edge detector its own copy of the line
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync1_q   <= 1'b1;
      rxs_q     <= 1'b1;
      rxsPrev_q <= 1'b1;
    end else begin
      sync1_q   <= rxd;
      rxs_q     <= sync1_q;
      rxsPrev_q <= rxs_q;
    end
  end

  rx_serial_tick #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_tick (
    .clock      (clock),
    .reset      (reset),
    .restart_i  (restart),
    .halfTick_o (halfTick),
    .fullTick_o (fullTick)
  );

  always_comb begin
    state_d     = state_q;
    bitCnt_d    = bitCnt_q;
    shift_d     = shift_q;
    parityBit_d = parityBit_q;
    frameErr_d  = frameErr_q;
    dados_d     = dados_q;
    valid_d     = valid_q;
    parErr_d    = parErr_q;
    frmErr_d    = frmErr_q;
    overrun_d   = overrun_q;

    if (valid_q && ready) valid_d = 1'b0;
    if (clear_overrun)    overrun_d = 1'b0;

    case (state_q)
      ST_IDLE: if (rxsPrev_q && !rxs_q) state_d = ST_START;
      ST_START: if (halfTick) begin
        if (rxs_q) state_d = ST_IDLE;
        else begin
          state_d    = ST_DATA;
          frameErr_d = 1'b0;
        end
      end
      ST_DATA: if (fullTick) begin
        shift_d  = {rxs_q, shift_q[DATA_BITS-1:1]};
        bitCnt_d = bitCnt_q + 4'd1;
        if (bitCnt_q == LAST_DATA)
          state_d = (PARITY_MODE == PARITY_NONE) ? ST_STOP : ST_PARITY;
      end
      ST_PARITY: if (fullTick) begin
        parityBit_d = rxs_q;
        state_d     = ST_STOP;
      end
      ST_STOP: if (fullTick) begin
        if (!rxs_q) frameErr_d = 1'b1;
        bitCnt_d = bitCnt_q + 4'd1;
        if (bitCnt_q == LAST_STOP) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        state_d = ST_IDLE;
        // a load in the same cycle as a consume wins, so valid stays high
        if (!valid_q || ready) begin
          dados_d  = shift_q;
          parErr_d = parityMismatch(^shift_q ^ parityBit_q, PARITY_MODE);
          frmErr_d = frameErr_q;
          valid_d  = 1'b1;
        end else begin
          overrun_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (state_d != state_q) bitCnt_d = '0;
  end

  assign restart = (state_d != state_q);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      bitCnt_q    <= '0;
      shift_q     <= '0;
      parityBit_q <= 1'b0;
      frameErr_q  <= 1'b0;
      dados_q     <= '0;
      valid_q     <= 1'b0;
      parErr_q    <= 1'b0;
      frmErr_q    <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      bitCnt_q    <= bitCnt_d;
      shift_q     <= shift_d;
      parityBit_q <= parityBit_d;
      frameErr_q  <= frameErr_d;
      dados_q     <= dados_d;
      valid_q     <= valid_d;
      parErr_q    <= parErr_d;
      frmErr_q    <= frmErr_d;
      overrun_q   <= overrun_d;
    end
  end

  assign dados         = dados_q;
  assign valid         = valid_q;
  assign parity_error  = parErr_q;
  assign framing_error = frmErr_q;
  assign overrun       = overrun_q;
  assign busy          = (state_q != ST_IDLE);
`ifdef RX_SERIAL_DEBUG_EN
  assign db_estado     = state_q;
`endif

endmodule
